// File: rtl/mc_ctrl_if.sv
// Bus bundle between the multicycle controller and its fetch/data memories and datapath.
// The controller takes the master view; memories and datapath take the slave view.
interface mc_ctrl_if;
    logic        imem_req;
    logic        imem_rdy;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_rdy;
    logic [31:0] instr;
    logic        br_taken;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        alu_src_b;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        halt;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] retire_cnt;

    modport master (
        output imem_req,
        input  imem_rdy,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_rdy,
        output instr,
        input  br_taken,
        output pc_we,
        output pc_sel,
        output alu_src_b,
        output rf_we,
        output wb_sel,
        output halt,
        output illegal,
        output state,
        output retire_cnt
    );

    modport slave (
        input  imem_req,
        output imem_rdy,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_rdy,
        input  instr,
        output br_taken,
        input  pc_we,
        input  pc_sel,
        input  alu_src_b,
        input  rf_we,
        input  wb_sel,
        input  halt,
        input  illegal,
        input  state,
        input  retire_cnt
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle RV32I-style control FSM: fetch, decode, execute, memory, write-back, halt.
// All strobes are decoded from the registered state so an async reset clears them at once.
module mc_ctrl (
    input  logic     clk,
    input  logic     rst_n,
    mc_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic        halt_q, halt_d;
    logic        illegal_q, illegal_d;

    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        alu_src_b;
    logic        rf_we;
    logic [1:0]  wb_sel;

    // Opcode classification of the latched instruction
    logic [6:0] opc;
    logic [4:0] rd;
    logic       is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic       is_load, is_store, is_opimm, is_op, is_system;
    logic       is_known, use_imm;

    assign opc       = instr_q[6:0];
    assign rd        = instr_q[11:7];
    assign is_lui    = (opc == OPC_LUI);
    assign is_auipc  = (opc == OPC_AUIPC);
    assign is_jal    = (opc == OPC_JAL);
    assign is_jalr   = (opc == OPC_JALR);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_load   = (opc == OPC_LOAD);
    assign is_store  = (opc == OPC_STORE);
    assign is_opimm  = (opc == OPC_OPIMM);
    assign is_op     = (opc == OPC_OP);
    assign is_system = (opc == OPC_SYSTEM);
    assign is_known  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                       is_load | is_store | is_opimm | is_op;
    assign use_imm   = is_opimm | is_load | is_store | is_jalr | is_auipc;

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        halt_d    = halt_q;
        illegal_d = illegal_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        alu_src_b = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_rdy) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // SYSTEM is a clean stop; anything unrecognised is flagged illegal
                if (is_system) begin
                    halt_d  = 1'b1;
                    state_d = S_HALT;
                end else if (!is_known) begin
                    halt_d    = 1'b1;
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_b = use_imm;
                if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = bus.br_taken ? 2'd1 : 2'd0;
                    state_d = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_src_b = use_imm;
                dmem_req  = 1'b1;
                dmem_we   = is_store;
                if (bus.dmem_rdy) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                alu_src_b = use_imm;
                pc_we     = 1'b1;
                rf_we     = (rd != 5'd0);
                if (is_jal) begin
                    pc_sel = 2'd1;
                end else if (is_jalr) begin
                    pc_sel = 2'd2;
                end
                if (is_load) begin
                    wb_sel = 2'd1;
                end else if (is_jal || is_jalr) begin
                    wb_sel = 2'd2;
                end else if (is_lui) begin
                    wb_sel = 2'd3;
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // Unused state encoding: stop and report it as illegal
                halt_d    = 1'b1;
                illegal_d = 1'b1;
                state_d   = S_HALT;
            end
        endcase

        retire_cnt_d = retire_cnt_q + {31'd0, pc_we};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            instr_q      <= 32'd0;
            retire_cnt_q <= 32'd0;
            halt_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            retire_cnt_q <= retire_cnt_d;
            halt_q       <= halt_d;
            illegal_q    <= illegal_d;
        end
    end

    assign bus.imem_req   = imem_req;
    assign bus.dmem_req   = dmem_req;
    assign bus.dmem_we    = dmem_we;
    assign bus.instr      = instr_q;
    assign bus.pc_we      = pc_we;
    assign bus.pc_sel     = pc_sel;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.rf_we      = rf_we;
    assign bus.wb_sel     = wb_sel;
    assign bus.halt       = halt_q;
    assign bus.illegal    = illegal_q;
    assign bus.state      = state_q;
    assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: imem_req out 1 fetch request; imem_rdy in 1 fetch data valid; imem_rdata in 32 fetched instruction.
REQ-004 SHALL have ports: dmem_req out 1 data access request; dmem_we out 1 store (1) / load (0); dmem_rdy in 1 access complete.
REQ-005 SHALL have ports: instr out 32 latched instruction register (drives imm_gen and regfile addresses); br_taken in 1 branch comparison result from ALU.
REQ-006 SHALL have ports: pc_we out 1 PC update strobe; pc_sel out 2 next-PC source (0 pc+4, 1 pc+imm, 2 (rs1+imm)&~1); alu_src_b out 1 (0 rs2, 1 imm); rf_we out 1; wb_sel out 2 (0 ALU, 1 mem, 2 pc+4, 3 imm).
REQ-007 SHALL have ports: halt out 1 sticky stop; illegal out 1 sticky illegal-opcode flag; state out 3 current state code; retire_cnt out 32 retired-instruction count.

Function
REQ-008 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; codes 7 unused and SHALL go to HALT with illegal=1.
REQ-009 IDLE SHALL drive all strobes 0 and transition unconditionally to FETCH next cycle.
REQ-010 FETCH SHALL hold imem_req=1 until imem_rdy=1; on that edge instr<=imem_rdata, next state DECODE; no timeout.
REQ-011 DECODE SHALL last exactly one cycle and classify instr[6:0]: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, SYSTEM 1110011.
REQ-012 DECODE SHALL go to HALT on SYSTEM (halt=1, illegal=0) or any other unlisted opcode including 32'h0 (halt=1, illegal=1); otherwise EXEC.
REQ-013 EXEC SHALL drive alu_src_b=1 for OP-IMM, LOAD, STORE, JALR, AUIPC, else 0; alu_src_b SHALL hold its value through MEM and WB.
REQ-014 EXEC for BRANCH SHALL pulse pc_we=1 with pc_sel=1 if br_taken else 0 and go to FETCH; LOAD/STORE go to MEM; all others go to WB.
REQ-015 MEM SHALL hold dmem_req=1 (dmem_we=1 for STORE) until dmem_rdy=1; then STORE pulses pc_we=1, pc_sel=0, goes FETCH; LOAD goes WB.
REQ-016 WB SHALL pulse pc_we=1 and rf_we=1 (rf_we=0 when instr[11:7]==0); pc_sel=1 for JAL, 2 for JALR, else 0.
REQ-017 wb_sel in WB SHALL be 1 LOAD, 2 JAL/JALR, 3 LUI, else 0 (AUIPC uses ALU path).
REQ-018 pc_we, rf_we SHALL be single-cycle pulses; each pc_we pulse SHALL increment retire_cnt by 1, wrapping 32'hFFFFFFFF->0.
REQ-019 Latency with zero wait states: BRANCH 3 cycles, STORE 4, ALU/LUI/AUIPC/JAL/JALR 4, LOAD 5, measured FETCH entry to next FETCH entry; each imem/dmem wait cycle adds 1.
REQ-020 HALT SHALL be absorbing: all strobes 0, instr and retire_cnt frozen, until rst_n asserted.
REQ-021 imem_rdy/dmem_rdy outside their respective request states SHALL be ignored.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, instr=0, retire_cnt=0, halt=0, illegal=0, all strobes and selects 0, including mid-FETCH/MEM wait.
REQ-023 First cycle after rst_n deassertion SHALL be IDLE; imem_req first rises one cycle after release.

Verification
REQ-024 Reset release, imem_rdy=1 always, imem_rdata=32'h12345637 (LUI x12) -> FETCH,DECODE,EXEC,WB; WB: rf_we=1, wb_sel=3, pc_we=1, pc_sel=0; retire_cnt=1.
REQ-025 imem_rdata=32'h8cdff603 (LOAD), dmem_rdy held 0 for 3 cycles -> dmem_req=1, dmem_we=0 for 4 cycles; then WB with wb_sel=1, rf_we=1; loop total 8 cycles.
REQ-026 imem_rdata=32'h75834863 (BRANCH), br_taken=1 -> EXEC pc_we=1, pc_sel=1, rf_we=0, back to FETCH after 3 cycles; repeat with br_taken=0 -> pc_sel=0.
REQ-027 imem_rdata=32'h6669996f (JAL) -> WB: pc_sel=1, wb_sel=2, rf_we=1; 32'h6cdff6e7 (JALR) -> pc_sel=2, alu_src_b=1.
REQ-028 imem_rdata=32'h0 -> halt=1, illegal=1 after DECODE, no pc_we; 32'h00100073 (EBREAK) -> halt=1, illegal=0; rst_n pulse -> IDLE, flags cleared.
REQ-029 rst_n asserted during MEM wait of a STORE (32'h02dff6a3) -> dmem_req drops same cycle, retire_cnt=0, no pc_we.
